// File: rtl/regfile_ctrl_pkg.sv
// Shared sizes and requester indices for the register-file writeback controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package regfile_ctrl_pkg;

  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int AW   = 5;

  // Writeback requester identity, also used as the round-robin pointer value
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; owns the priority pointer.
// Latency: grant is combinational from requests; pointer updates at the next edge.
// Backpressure: a request not granted simply waits; pointer only moves on a grant.
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  req_idx_t r_ptr;
  req_idx_t w_ptr_nxt;

  // Grant the lone requester, or the pointed-to one on contention; move the pointer past the winner
  always_comb begin
    o_gnt0    = 1'b0;
    o_gnt1    = 1'b0;
    w_ptr_nxt = r_ptr;
    if (!reset) begin
      if (i_req0 && (!i_req1 || r_ptr == REQ_ALU)) begin
        o_gnt0 = 1'b1;
      end else if (i_req1) begin
        o_gnt1 = 1'b1;
      end
      if (o_gnt0) begin
        w_ptr_nxt = REQ_LSU;
      end else if (o_gnt1) begin
        w_ptr_nxt = REQ_ALU;
      end
    end
  end

  // Pointer register; holds on idle cycles, favours the ALU out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= REQ_ALU;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: busy scoreboard, 2-way writeback arbitration, registered RF write port.
// Latency: ready/busy queries combinational; we3/a3/wd3 one cycle after the transfer.
// Backpressure: a writeback waits while the other requester wins; reservation refused while target busy.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int NREG = regfile_ctrl_pkg::NREG,
  parameter int DW   = regfile_ctrl_pkg::DW,
  parameter int AW   = regfile_ctrl_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          res_en,
  input  logic [AW-1:0] res_rd,
  output logic          res_ready,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_rd,
  input  logic [DW-1:0] wb0_data,
  output logic          wb0_ready,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_rd,
  input  logic [DW-1:0] wb1_data,
  output logic          wb1_ready,
  output logic          we3,
  output logic [AW-1:0] a3,
  output logic [DW-1:0] wd3,
  input  logic [AW-1:0] q_a1,
  input  logic [AW-1:0] q_a2,
  output logic          q_busy1,
  output logic          q_busy2,
  output logic          err_unres
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_xfer;
  logic            w_wr;
  logic [AW-1:0]   w_rd;
  logic [DW-1:0]   w_data;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_req0 (wb0_valid),
    .i_req1 (wb1_valid),
    .o_gnt0 (wb0_ready),
    .o_gnt1 (wb1_ready)
  );

  assign w_xfer = wb0_ready | wb1_ready;
  assign w_rd   = wb1_ready ? wb1_rd   : wb0_rd;
  assign w_data = wb1_ready ? wb1_data : wb0_data;
  // x0 writebacks are accepted but never reach the register file
  assign w_wr   = w_xfer && (w_rd != '0);

  assign res_ready = !reset && res_en && ((res_rd == '0) || !r_busy[res_rd]);

  // Hazard queries see only the scoreboard; an in-flight we3 is not bypassed
  assign q_busy1 = (q_a1 != '0) && r_busy[q_a1];
  assign q_busy2 = (q_a2 != '0) && r_busy[q_a2];

  // Scoreboard set/clear masks; set wins over clear so a racing reservation is never lost
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (res_ready && (res_rd != '0)) begin
      w_set[res_rd] = 1'b1;
    end
    if (we3) begin
      w_clr[a3] = 1'b1;
    end
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  // Busy vector; bit 0 is tied low because x0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= {w_busy_nxt[NREG-1:1], 1'b0};
    end
  end

  // Register-file write port; address/data hold when no write is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= w_wr;
      if (w_wr) begin
        a3  <= w_rd;
        wd3 <= w_data;
      end
    end
  end

  // Sticky error: a real write arrived for a register nobody reserved
  always_ff @(posedge clk) begin
    if (reset) begin
      err_unres <= 1'b0;
    end else if (w_wr && !r_busy[w_rd]) begin
      err_unres <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl: directed scenarios plus randomized traffic vs. a reference model.
// Latency: checks combinational outputs mid-cycle and registered outputs 1ns after each edge.
// Backpressure: requesters hold valid/rd/data until granted.
module tb_regfile_wb_ctrl;
  import regfile_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          res_en;
  logic [AW-1:0] res_rd;
  logic          res_ready;
  logic          wb0_valid, wb1_valid;
  logic [AW-1:0] wb0_rd, wb1_rd;
  logic [DW-1:0] wb0_data, wb1_data;
  logic          wb0_ready, wb1_ready;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] q_a1, q_a2;
  logic          q_busy1, q_busy2;
  logic          err_unres;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit            m_busy [NREG];
  int            m_ptr;
  bit            m_we;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd3;
  bit            m_err;

  // Observed handshakes of the most recent cycle
  logic obs_res, obs_g0, obs_g1;

  regfile_wb_ctrl dut (
    .clk       (clk),
    .reset     (rst),
    .res_en    (res_en),
    .res_rd    (res_rd),
    .res_ready (res_ready),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .q_a1      (q_a1),
    .q_a2      (q_a2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2),
    .err_unres (err_unres)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; res_en = 1'b0; res_rd = '0;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    q_a1 = '0; q_a2 = '0;
  endtask

  // One clock cycle with the inputs currently driven; returns 1ns after the edge
  task automatic cycle();
    int            g;
    bit            exp_res;
    bit            nb [NREG];
    logic [AW-1:0] rd;
    logic [DW-1:0] dat;
    #1;
    exp_res = !rst && res_en && (res_rd == 0 || !m_busy[res_rd]);
    g = -1;
    if (!rst) begin
      if (wb0_valid && wb1_valid) g = m_ptr;
      else if (wb0_valid)         g = 0;
      else if (wb1_valid)         g = 1;
    end
    chk("res_ready", 64'(res_ready), 64'(exp_res));
    chk("wb0_ready", 64'(wb0_ready), 64'(g == 0));
    chk("wb1_ready", 64'(wb1_ready), 64'(g == 1));
    chk("q_busy1", 64'(q_busy1), 64'(q_a1 != 0 && m_busy[q_a1]));
    chk("q_busy2", 64'(q_busy2), 64'(q_a2 != 0 && m_busy[q_a2]));
    obs_res = res_ready; obs_g0 = wb0_ready; obs_g1 = wb1_ready;

    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_err = 1'b0;
    end else begin
      nb = m_busy;
      if (m_we) nb[m_a3] = 1'b0;
      if (exp_res && res_rd != 0) nb[res_rd] = 1'b1;
      if (g >= 0) begin
        rd  = (g == 1) ? wb1_rd   : wb0_rd;
        dat = (g == 1) ? wb1_data : wb0_data;
        if (rd != 0 && !m_busy[rd]) m_err = 1'b1;
        m_we = (rd != 0);
        if (rd != 0) begin
          m_a3 = rd; m_wd3 = dat;
        end
        m_ptr = 1 - g;
      end else begin
        m_we = 1'b0;
      end
      m_busy = nb;
    end

    @(posedge clk);
    #1;
    chk("we3", 64'(we3), 64'(m_we));
    chk("a3", 64'(a3), 64'(m_a3));
    chk("wd3", 64'(wd3), 64'(m_wd3));
    chk("err_unres", 64'(err_unres), 64'(m_err));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] r0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_err = 1'b0;
    obs_res = 1'b0; obs_g0 = 1'b0; obs_g1 = 1'b0;

    // Reset state
    do_reset();
    chk("rst_we3", 64'(we3), 64'(0));
    chk("rst_a3", 64'(a3), 64'(0));
    chk("rst_wd3", 64'(wd3), 64'(0));
    chk("rst_err", 64'(err_unres), 64'(0));

    // Reserve x5, writeback from ALU
    res_en = 1'b1; res_rd = 5'd5; cycle();
    res_en = 1'b0; q_a1 = 5'd5;
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF; cycle();
    chk("x5_gnt", 64'(obs_g0), 64'(1));
    chk("x5_we3", 64'(we3), 64'(1));
    chk("x5_a3", 64'(a3), 64'(5));
    chk("x5_wd3", 64'(wd3), 64'hDEADBEEF);
    wb0_valid = 1'b0; cycle();
    chk("x5_we3_drop", 64'(we3), 64'(0));
    chk("x5_busy_clr", 64'(q_busy1), 64'(0));

    // Contention: alternating grants, back-to-back writes
    do_reset();
    res_en = 1'b1; res_rd = 5'd3; cycle();
    res_rd = 5'd4; cycle();
    res_en = 1'b0;
    wb0_valid = 1'b1; wb0_rd = 5'd3;
    wb1_valid = 1'b1; wb1_rd = 5'd4;
    for (int k = 0; k < 4; k++) begin
      wb0_data = 32'hA000_0000 + k;
      wb1_data = 32'hB000_0000 + k;
      cycle();
      chk("rr_gnt0", 64'(obs_g0), 64'(k % 2 == 0));
      chk("rr_gnt1", 64'(obs_g1), 64'(k % 2 == 1));
      chk("rr_we3", 64'(we3), 64'(1));
      chk("rr_a3", 64'(a3), 64'((k % 2 == 0) ? 3 : 4));
    end
    idle_inputs(); cycle();

    // Reservation blocked while busy, released after writeback
    do_reset();
    res_en = 1'b1; res_rd = 5'd7; q_a1 = 5'd7; cycle();
    cycle();
    chk("x7_res_blocked", 64'(obs_res), 64'(0));
    chk("x7_busy", 64'(q_busy1), 64'(1));
    res_en = 1'b0; wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h77; cycle();
    wb1_valid = 1'b0; cycle();
    res_en = 1'b1; cycle();
    chk("x7_res_again", 64'(obs_res), 64'(1));
    idle_inputs(); cycle();

    // x0 writeback is a no-op; unreserved write raises the sticky error
    do_reset();
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h1234; cycle();
    chk("x0_gnt", 64'(obs_g1), 64'(1));
    chk("x0_we3", 64'(we3), 64'(0));
    chk("x0_err", 64'(err_unres), 64'(0));
    wb1_valid = 1'b0; wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h99; cycle();
    chk("x9_err", 64'(err_unres), 64'(1));
    wb0_valid = 1'b0; cycle(); cycle();
    chk("x9_err_sticky", 64'(err_unres), 64'(1));

    // Reset racing a writeback to x2: nothing survives
    do_reset();
    res_en = 1'b1; res_rd = 5'd2; q_a1 = 5'd2; cycle();
    res_en = 1'b0; wb0_valid = 1'b1; wb0_rd = 5'd2; wb0_data = 32'h22; rst = 1'b1; cycle();
    chk("rst_race_gnt", 64'(obs_g0), 64'(0));
    idle_inputs(); q_a1 = 5'd2; cycle();
    chk("rst_race_we3", 64'(we3), 64'(0));
    chk("rst_race_busy", 64'(q_busy1), 64'(0));
    res_en = 1'b1; res_rd = 5'd2; cycle();
    res_en = 1'b0; wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h23; cycle();
    wb1_valid = 1'b0; rst = 1'b1; cycle();
    rst = 1'b0; cycle();
    chk("rst_we3_after", 64'(we3), 64'(0));
    chk("rst_busy_after", 64'(q_busy1), 64'(0));
    chk("rst_err_after", 64'(err_unres), 64'(0));
    wb0_valid = 1'b1; wb1_valid = 1'b1; cycle();
    chk("rst_ptr_alu", 64'(obs_g0), 64'(1));
    idle_inputs(); cycle();

    // Randomized traffic; requesters hold until granted
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!wb0_valid && $urandom_range(0, 1) == 1) begin
        wb0_valid = 1'b1; wb0_rd = AW'($urandom_range(0, 7)); wb0_data = $urandom;
      end
      if (!wb1_valid && $urandom_range(0, 2) == 0) begin
        wb1_valid = 1'b1; wb1_rd = AW'($urandom_range(0, 7)); wb1_data = $urandom;
      end
      res_en = ($urandom_range(0, 1) == 1);
      r0 = AW'($urandom_range(0, 7));
      res_rd = r0;
      q_a1 = AW'($urandom_range(0, 7));
      q_a2 = AW'($urandom_range(0, NREG - 1));
      cycle();
      if (obs_g0) wb0_valid = 1'b0;
      if (obs_g1) wb1_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameters: NREG = 32, number of architectural registers; DW = 32, data width; AW = 5, register address width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 res_en  in  1  issue stage requests reservation of destination res_rd.
REQ-004 res_rd  in  AW  destination register to reserve.
REQ-005 res_ready  out  1  reservation accepted this cycle (combinational).
REQ-006 wb0_valid / wb0_rd / wb0_data  in  1 / AW / DW  writeback requester 0 (ALU).
REQ-007 wb0_ready  out  1  requester 0 granted (combinational).
REQ-008 wb1_valid / wb1_rd / wb1_data  in  1 / AW / DW  writeback requester 1 (load/multicycle unit).
REQ-009 wb1_ready  out  1  requester 1 granted (combinational).
REQ-010 we3 / a3 / wd3  out  1 / AW / DW  registered register-file write port.
REQ-011 q_a1, q_a2  in  AW  hazard-query addresses from decode.
REQ-012 q_busy1, q_busy2  out  1  queried register has an outstanding write (combinational).
REQ-013 err_unres  out  1  sticky flag: writeback accepted to a non-reserved register.

Function
REQ-014 The block SHALL keep a busy vector of NREG bits; bit 0 SHALL never be set.
REQ-015 Writeback handshake: a transfer occurs on a cycle with wbN_valid && wbN_ready; at most one transfer per cycle.
REQ-016 Only one valid: that requester SHALL be granted the same cycle.
REQ-017 Both valid: round-robin; the grant goes to the requester indicated by the priority pointer, and the pointer then points to the other requester; the pointer SHALL not change on cycles with no transfer.
REQ-018 Latency: the cycle after a transfer with rd != 0, we3 = 1 and a3/wd3 = the transferred rd/data; otherwise we3 = 0 and a3/wd3 hold their previous values.
REQ-019 A transfer with rd = 0 SHALL be accepted and SHALL produce no write and no busy change.
REQ-020 busy[rd] SHALL clear at the clock edge that ends the cycle in which we3 = 1 for that rd.
REQ-021 res_ready = res_en && (res_rd == 0 || !busy[res_rd]); an accepted reservation with res_rd != 0 SHALL set busy[res_rd] at the next edge.
REQ-022 Simultaneous set and clear of the same bit SHALL leave the bit set. This cannot follow from an accepted reservation, since busy = 1 blocks it; it covers robustness only.
REQ-023 q_busyN = (q_aN != 0) && busy[q_aN]; no bypass of in-flight we3.
REQ-024 err_unres SHALL set when a transfer with rd != 0 finds busy[rd] = 0, and SHALL clear only on reset.
REQ-025 A valid requester SHALL be held stable by its producer until granted; the block makes no assumption when valid drops without a grant.

Reset
REQ-026 While reset is high at a rising edge: busy = 0, we3 = 0, a3 = 0, wd3 = 0, priority pointer = requester 0, err_unres = 0.
REQ-027 While reset is high, wb0_ready, wb1_ready and res_ready SHALL be 0.
REQ-028 A write accepted in the cycle reset is asserted SHALL be discarded, with no we3 after reset.

Structure
REQ-029 Package regfile_ctrl_pkg SHALL hold NREG, AW, DW and the requester index type (REQ_ALU = 0, REQ_LSU = 1).
REQ-030 One sub-module, rr_arbiter2, SHALL contain the two-input round-robin grant logic and the priority pointer; busy vector, output register and error flag stay in the top module.

Verification
REQ-031 Reserve x5, then wb0 rd = 5 data 0xDEADBEEF -> wb0_ready = 1 same cycle; next cycle we3 = 1, a3 = 5, wd3 = 0xDEADBEEF; busy[5] = 0 after that edge.
REQ-032 Both requesters valid continuously for 4 transfers, rd = 3 and 4 reserved alternately -> grants wb0, wb1, wb0, wb1; we3 pulses 4 consecutive cycles.
REQ-033 Reserve x7, query q_a1 = 7 -> q_busy1 = 1; second res_en on x7 -> res_ready = 0; after writeback to x7 -> res_ready = 1.
REQ-034 wb1 rd = 0 data 0x1234 -> wb1_ready = 1, we3 stays 0, busy unchanged, err_unres = 0; wb0 rd = 9 unreserved -> err_unres = 1 and stays 1.
REQ-035 Assert reset in the cycle a wb0 transfer to x2 completes -> we3 = 0 on following cycles, busy = 0, pointer = wb0, err_unres = 0.
